// File: rtl/id_ex_if.sv
`default_nettype none
// ------------------------------------------------------------------
// id_ex_if : decode-side inputs and EX-side outputs of the ID/EX stage
// rev 1.0
// ------------------------------------------------------------------
interface id_ex_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [DATA_W-1:0] id_pc4;
  logic [4:0]        id_rs, id_rt, id_rd, id_shamt;
  logic [DATA_W-1:0] id_imm, id_rs_data, id_rt_data;
  logic              id_uses_rs, id_uses_rt;
  logic              id_regwrite, id_memread, id_memwrite;
  logic              id_alusrc1, id_alusrc2, id_branch;
  logic [1:0]        id_regdst, id_memtoreg;
  logic [3:0]        id_aluop;
  logic              ex_flush, mem_stall;

  logic              id_stall;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_pc4;
  logic [4:0]        ex_rs, ex_rt, ex_rd, ex_shamt;
  logic [DATA_W-1:0] ex_imm, ex_rs_data, ex_rt_data;
  logic              ex_uses_rs, ex_uses_rt;
  logic              ex_regwrite, ex_memread, ex_memwrite;
  logic              ex_alusrc1, ex_alusrc2, ex_branch;
  logic [1:0]        ex_regdst, ex_memtoreg;
  logic [3:0]        ex_aluop;
  logic [4:0]        ex_wr_addr;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output id_valid, id_pc4, id_rs, id_rt, id_rd, id_shamt, id_imm, id_rs_data, id_rt_data,
           id_uses_rs, id_uses_rt, id_regwrite, id_memread, id_memwrite, id_alusrc1,
           id_alusrc2, id_branch, id_regdst, id_memtoreg, id_aluop, ex_flush, mem_stall,
    input  id_stall, ex_valid, ex_pc4, ex_rs, ex_rt, ex_rd, ex_shamt, ex_imm, ex_rs_data,
           ex_rt_data, ex_uses_rs, ex_uses_rt, ex_regwrite, ex_memread, ex_memwrite,
           ex_alusrc1, ex_alusrc2, ex_branch, ex_regdst, ex_memtoreg, ex_aluop,
           ex_wr_addr, bubble_cnt
  );

  modport slave (
    input  id_valid, id_pc4, id_rs, id_rt, id_rd, id_shamt, id_imm, id_rs_data, id_rt_data,
           id_uses_rs, id_uses_rt, id_regwrite, id_memread, id_memwrite, id_alusrc1,
           id_alusrc2, id_branch, id_regdst, id_memtoreg, id_aluop, ex_flush, mem_stall,
    output id_stall, ex_valid, ex_pc4, ex_rs, ex_rt, ex_rd, ex_shamt, ex_imm, ex_rs_data,
           ex_rt_data, ex_uses_rs, ex_uses_rt, ex_regwrite, ex_memread, ex_memwrite,
           ex_alusrc1, ex_alusrc2, ex_branch, ex_regdst, ex_memtoreg, ex_aluop,
           ex_wr_addr, bubble_cnt
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ------------------------------------------------------------------
// id_ex_stage : ID/EX pipeline register with load-use bubble insertion
// rev 1.0
// ------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  wire logic clk,
  input  wire logic reset,
  id_ex_if.slave    bus
);
  localparam logic [4:0] REG_RA = 5'd31;

  logic       load_use;
  logic       bubble;
  logic [4:0] wr_addr;

  assign load_use = bus.ex_valid & bus.ex_memread & (bus.ex_wr_addr != 5'd0) & bus.id_valid &
                    ((bus.id_uses_rs & (bus.ex_wr_addr == bus.id_rs)) |
                     (bus.id_uses_rt & (bus.ex_wr_addr == bus.id_rt)));

  assign bus.id_stall = ~bus.ex_flush & (bus.mem_stall | load_use);
  // flush outranks a freeze; a freeze outranks a load-use bubble
  assign bubble = bus.ex_flush | (~bus.mem_stall & load_use);

  always_comb begin
    wr_addr = 5'd0;
    case (bus.id_regdst)
      2'b00:   wr_addr = bus.id_rt;
      2'b01:   wr_addr = bus.id_rd;
      2'b10:   wr_addr = REG_RA;
      default: wr_addr = 5'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset || bubble) begin
      bus.ex_valid    <= 1'b0;
      bus.ex_pc4      <= '0;
      bus.ex_rs       <= '0;
      bus.ex_rt       <= '0;
      bus.ex_rd       <= '0;
      bus.ex_shamt    <= '0;
      bus.ex_imm      <= '0;
      bus.ex_rs_data  <= '0;
      bus.ex_rt_data  <= '0;
      bus.ex_uses_rs  <= 1'b0;
      bus.ex_uses_rt  <= 1'b0;
      bus.ex_regwrite <= 1'b0;
      bus.ex_memread  <= 1'b0;
      bus.ex_memwrite <= 1'b0;
      bus.ex_alusrc1  <= 1'b0;
      bus.ex_alusrc2  <= 1'b0;
      bus.ex_branch   <= 1'b0;
      bus.ex_regdst   <= '0;
      bus.ex_memtoreg <= '0;
      bus.ex_aluop    <= '0;
      bus.ex_wr_addr  <= '0;
    end else if (!bus.mem_stall) begin
      bus.ex_valid    <= bus.id_valid;
      bus.ex_pc4      <= bus.id_pc4;
      bus.ex_rs       <= bus.id_rs;
      bus.ex_rt       <= bus.id_rt;
      bus.ex_rd       <= bus.id_rd;
      bus.ex_shamt    <= bus.id_shamt;
      bus.ex_imm      <= bus.id_imm;
      bus.ex_rs_data  <= bus.id_rs_data;
      bus.ex_rt_data  <= bus.id_rt_data;
      bus.ex_uses_rs  <= bus.id_uses_rs;
      bus.ex_uses_rt  <= bus.id_uses_rt;
      bus.ex_regwrite <= bus.id_regwrite & bus.id_valid;
      bus.ex_memread  <= bus.id_memread  & bus.id_valid;
      bus.ex_memwrite <= bus.id_memwrite & bus.id_valid;
      bus.ex_alusrc1  <= bus.id_alusrc1  & bus.id_valid;
      bus.ex_alusrc2  <= bus.id_alusrc2  & bus.id_valid;
      bus.ex_branch   <= bus.id_branch   & bus.id_valid;
      bus.ex_regdst   <= bus.id_regdst;
      bus.ex_memtoreg <= bus.id_memtoreg;
      bus.ex_aluop    <= bus.id_aluop;
      bus.ex_wr_addr  <= wr_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.bubble_cnt <= '0;
    end else if (!bus.ex_flush && !bus.mem_stall && load_use && (bus.bubble_cnt != {CNT_W{1'b1}})) begin
      bus.bubble_cnt <= bus.bubble_cnt + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// Directed bench for id_ex_stage; small counter width makes saturation reachable.
module tb_id_ex_stage;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 3;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  id_ex_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic urs, input logic urt, input logic rw,
                       input logic mr, input logic [1:0] rdst);
    bus.id_valid    = v;
    bus.id_pc4      = pc;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_rd       = rd;
    bus.id_shamt    = 5'd3;
    bus.id_imm      = pc ^ 32'h0000_FFFF;
    bus.id_rs_data  = 32'hA000_0000 | pc;
    bus.id_rt_data  = 32'hB000_0000 | pc;
    bus.id_uses_rs  = urs;
    bus.id_uses_rt  = urt;
    bus.id_regwrite = rw;
    bus.id_memread  = mr;
    bus.id_memwrite = 1'b0;
    bus.id_alusrc1  = 1'b0;
    bus.id_alusrc2  = mr;
    bus.id_branch   = 1'b0;
    bus.id_regdst   = rdst;
    bus.id_memtoreg = mr ? 2'b01 : 2'b00;
    bus.id_aluop    = 4'h2;
  endtask

  // lw $rt, 0($9)
  task automatic lw(input logic [31:0] pc, input logic [4:0] rt);
    drive(1'b1, pc, 5'd9, rt, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus.ex_flush  = 1'b0;
    bus.mem_stall = 1'b0;
    reset = 1'b0;
    lw(32'h100, 5'd8);
    step();
    step();
    check("rst_valid", 64'(bus.ex_valid), 64'd0);
    check("rst_wr", 64'(bus.ex_wr_addr), 64'd0);
    check("rst_cnt", 64'(bus.bubble_cnt), 64'd0);
    check("rst_pc4", 64'(bus.ex_pc4), 64'd0);
    check("rst_rw", 64'(bus.ex_regwrite), 64'd0);

    // lw $8 then add $9,$8,$10
    reset = 1'b1;
    lw(32'h104, 5'd8);
    step();
    check("lw_valid", 64'(bus.ex_valid), 64'd1);
    check("lw_wr", 64'(bus.ex_wr_addr), 64'd8);
    check("lw_mr", 64'(bus.ex_memread), 64'd1);
    check("lw_pc4", 64'(bus.ex_pc4), 64'h104);
    check("lw_aluop", 64'(bus.ex_aluop), 64'h2);
    drive(1'b1, 32'h108, 5'd8, 5'd10, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01);
    #1;
    check("lu_stall", 64'(bus.id_stall), 64'd1);
    step();
    check("lu_bub_valid", 64'(bus.ex_valid), 64'd0);
    check("lu_bub_rw", 64'(bus.ex_regwrite), 64'd0);
    check("lu_bub_mr", 64'(bus.ex_memread), 64'd0);
    check("lu_bub_pc4", 64'(bus.ex_pc4), 64'd0);
    check("lu_cnt", 64'(bus.bubble_cnt), 64'd1);
    check("lu_stall_drop", 64'(bus.id_stall), 64'd0);
    step();
    check("add_valid", 64'(bus.ex_valid), 64'd1);
    check("add_wr", 64'(bus.ex_wr_addr), 64'd9);
    check("add_pc4", 64'(bus.ex_pc4), 64'h108);
    check("add_rsdata", 64'(bus.ex_rs_data), 64'hA000_0108);
    check("add_imm", 64'(bus.ex_imm), 64'h0000_FEF7);

    // lw $0 then add $9,$0,$1
    lw(32'h10C, 5'd0);
    step();
    check("lw0_wr", 64'(bus.ex_wr_addr), 64'd0);
    drive(1'b1, 32'h110, 5'd0, 5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01);
    #1;
    check("lw0_stall", 64'(bus.id_stall), 64'd0);
    step();
    check("lw0_add_wr", 64'(bus.ex_wr_addr), 64'd9);
    check("lw0_cnt", 64'(bus.bubble_cnt), 64'd1);

    // lw $8 then addi $8,$9,4 (rt is the destination, not a source)
    lw(32'h114, 5'd8);
    step();
    drive(1'b1, 32'h118, 5'd9, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
    #1;
    check("addi_stall", 64'(bus.id_stall), 64'd0);
    step();
    check("addi_wr", 64'(bus.ex_wr_addr), 64'd8);
    check("addi_valid", 64'(bus.ex_valid), 64'd1);
    check("addi_cnt", 64'(bus.bubble_cnt), 64'd1);

    // jal, then flush concurrent with load-use
    drive(1'b1, 32'h11C, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10);
    step();
    check("jal_wr", 64'(bus.ex_wr_addr), 64'd31);
    lw(32'h120, 5'd8);
    step();
    drive(1'b1, 32'h124, 5'd8, 5'd10, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01);
    bus.ex_flush = 1'b1;
    #1;
    check("fl_stall", 64'(bus.id_stall), 64'd0);
    step();
    bus.ex_flush = 1'b0;
    check("fl_valid", 64'(bus.ex_valid), 64'd0);
    check("fl_rw", 64'(bus.ex_regwrite), 64'd0);
    check("fl_cnt", 64'(bus.bubble_cnt), 64'd1);

    // mem_stall for three cycles holds the lw in EX
    lw(32'h200, 5'd5);
    step();
    drive(1'b1, 32'h204, 5'd1, 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
    bus.mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ms_stall", 64'(bus.id_stall), 64'd1);
      step();
      check("ms_hold_wr", 64'(bus.ex_wr_addr), 64'd5);
      check("ms_hold_pc4", 64'(bus.ex_pc4), 64'h200);
      check("ms_hold_mr", 64'(bus.ex_memread), 64'd1);
    end
    bus.mem_stall = 1'b0;
    #1;
    check("ms_release_stall", 64'(bus.id_stall), 64'd0);
    step();
    check("ms_resume_wr", 64'(bus.ex_wr_addr), 64'd6);
    check("ms_resume_pc4", 64'(bus.ex_pc4), 64'h204);

    // invalid instruction: control gated
    drive(1'b0, 32'h208, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01);
    step();
    check("inv_valid", 64'(bus.ex_valid), 64'd0);
    check("inv_rw", 64'(bus.ex_regwrite), 64'd0);
    check("inv_mr", 64'(bus.ex_memread), 64'd0);

    // drive counter to saturation and one beyond
    for (int i = 0; i < 7; i++) begin
      lw(32'h300 + 32'(i * 8), 5'd8);
      step();
      drive(1'b1, 32'h304 + 32'(i * 8), 5'd8, 5'd10, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01);
      step();
      step();
    end
    check("sat_cnt", 64'(bus.bubble_cnt), 64'd7);
    check("sat_last_wr", 64'(bus.ex_wr_addr), 64'd9);

    // reset while a load-use stall is pending
    lw(32'h400, 5'd8);
    step();
    drive(1'b1, 32'h404, 5'd8, 5'd10, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01);
    #1;
    check("rs_stall_pre", 64'(bus.id_stall), 64'd1);
    reset = 1'b0;
    step();
    check("rs_valid", 64'(bus.ex_valid), 64'd0);
    check("rs_cnt", 64'(bus.bubble_cnt), 64'd0);
    check("rs_wr", 64'(bus.ex_wr_addr), 64'd0);
    check("rs_mr", 64'(bus.ex_memread), 64'd0);
    check("rs_stall_in", 64'(bus.id_stall), 64'd0);
    reset = 1'b1;
    #1;
    check("rs_stall_post", 64'(bus.id_stall), 64'd0);
    step();
    check("rs_add_wr", 64'(bus.ex_wr_addr), 64'd9);
    check("rs_add_valid", 64'(bus.ex_valid), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
